// File: rtl/csa_serial_sub.sv
// Serial subtractor: diff = op_a - op_b computed one 3-bit carry-select slice per clock, LSB first.
// Optional signed-overflow output `ovf` is built only when SUB_OVF_EN is defined.
module csa_serial_sub #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SW = 3;
  localparam int unsigned N  = WIDTH / SW;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0]    LAST_CNT   = CW'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'(7);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef SUB_OVF_EN
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0] a_sh, nb_sh;
  logic [SW-1:0]    a_k, nb_k;
  logic [SW:0]      sum0, sum1, sel;

  // Both carry-in candidates are formed in parallel; the registered carry picks one.
  always_comb begin
    a_sh  = a_q >> (SW * cnt_q);
    nb_sh = nb_q >> (SW * cnt_q);
    a_k   = a_sh[SW-1:0];
    nb_k  = nb_sh[SW-1:0];
    sum0  = {1'b0, a_k} + {1'b0, nb_k};
    sum1  = sum0 + (SW+1)'(1);
    sel   = carry_q ? sum1 : sum0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    nb_d     = nb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_OVF_EN
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          nb_d    = ~op_b;
          diff_d  = '0;
          cnt_d   = '0;
          carry_d = 1'b1;
          state_d = S_RUN;
`ifdef SUB_OVF_EN
          b_msb_d = op_b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        diff_d  = (diff_q & ~(SLICE_MASK << (SW * cnt_q)))
                | (WIDTH'(sel[SW-1:0]) << (SW * cnt_q));
        carry_d = sel[SW];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = S_DONE;
          borrow_d = ~sel[SW];
`ifdef SUB_OVF_EN
          ovf_d    = (a_q[WIDTH-1] != b_msb_q) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      a_q      <= '0;
      nb_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SUB_OVF_EN
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
